vending_sequencer: RTL

VENDING_SEQUENCER -- requirements
Module: vending_sequencer

---
 rtl/vending_pkg.sv | 49 ++++
 rtl/vending_sequencer_step_timer.sv | 45 ++++
 rtl/vending_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared types for the vending sequencer: FSM states, ingredient indices,
// recipe record and the fixed recipe table.
package vending_pkg;

    localparam int PKG_NUM_INGR    = 5;
    localparam int PKG_NUM_RECIPES = 5;
    localparam int PKG_CREDIT_W    = 4;
    localparam int PKG_DUR_W       = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    localparam int INGR_WATER  = 0;
    localparam int INGR_COFFEE = 1;
    localparam int INGR_SUGAR  = 2;
    localparam int INGR_MILK   = 3;
    localparam int INGR_CHOC   = 4;

    typedef logic [PKG_DUR_W-1:0] dur_t;

    // dur[i] is the duration in ticks of ingredient i (water at index 0).
    typedef struct packed {
        logic [PKG_CREDIT_W-1:0] price;
        dur_t [PKG_NUM_INGR-1:0] dur;
    } recipe_t;

    // Durations are listed chocolate, milk, sugar, coffee, water (MSB first).
    localparam recipe_t RECIPE_TABLE [PKG_NUM_RECIPES] = '{
        '{price: 4'd2, dur: {2'd0, 2'd0, 2'd0, 2'd2, 2'd1}},
        '{price: 4'd3, dur: {2'd0, 2'd0, 2'd0, 2'd1, 2'd3}},
        '{price: 4'd4, dur: {2'd0, 2'd0, 2'd2, 2'd1, 2'd1}},
        '{price: 4'd5, dur: {2'd2, 2'd1, 2'd0, 2'd1, 2'd1}},
        '{price: 4'd1, dur: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}}
    };

    // Out-of-table selections return an all-zero recipe; callers gate on validity.
    function automatic recipe_t recipe_lookup(input logic [2:0] sel);
        recipe_t r;
        r = '0;
        for (int i = 0; i < PKG_NUM_RECIPES; i++) begin
            if (sel == 3'(i)) r = RECIPE_TABLE[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/vending_sequencer_step_timer.sv
// Dispense step timer: a TICK_DIV prescaler feeding a tick countdown.
// done pulses in the last cycle of a step so the next step can start back-to-back.
module step_timer
    import vending_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DUR_W    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DUR_W-1:0] duration,
    output logic             done
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [DUR_W-1:0] ticks;
    logic             active;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre    <= '0;
            ticks  <= '0;
            active <= 1'b0;
        end else if (start) begin
            pre    <= PRE_MAX;
            ticks  <= duration;
            active <= (duration != '0);
        end else if (active) begin
            if (pre == '0) begin
                pre   <= PRE_MAX;
                ticks <= ticks - DUR_W'(1);
                if (ticks == DUR_W'(1)) active <= 1'b0;
            end else begin
                pre <= pre - PRE_W'(1);
            end
        end
    end

    assign done = active && (pre == '0) && (ticks == DUR_W'(1));

endmodule

// File: rtl/vending_sequencer.sv
// Coffee vending sequencer: coin credit, recipe accept/reject, timed valve
// sequencing and change return. Define COIN_500_EN to add the coin_500 input.
module vending_sequencer
    import vending_pkg::*;
#(
    parameter int NUM_INGR    = 5,
    parameter int NUM_RECIPES = 5,
    parameter int CREDIT_W    = 4,
    parameter int MAX_CREDIT  = 15,
    parameter int TICK_DIV    = 50_000_000,
    parameter int DUR_W       = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_100,
`ifdef COIN_500_EN
    input  logic                coin_500,
`endif
    input  logic [2:0]          coffee_type,
    input  logic                confirm,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic [NUM_INGR-1:0] ingr_en,
    output logic                busy,
    output logic                finished,
    output logic                err,
    output state_t              state_dbg
);

    // Handshake: none of the inputs are valid/ready; each is a level whose
    // rising edge (versus its registered copy) is one request, and every
    // pulse output is high for exactly one cycle with no back-pressure.

    localparam int IDX_W = $clog2(NUM_INGR);
    localparam int SUM_W = CREDIT_W + 3;

    state_t state, state_next;
    logic [CREDIT_W-1:0] credit_next, change_next;
    logic change_valid_next, finished_next, err_next;
    dur_t [PKG_NUM_INGR-1:0] dur_q, dur_next;
    logic [IDX_W-1:0] step_idx, idx_next;
    logic no_steps, no_steps_next;

    logic coin_100_q, confirm_q, cancel_q;
    logic coin_100_rise, coin_500_rise, confirm_rise, cancel_rise;
    logic [SUM_W-1:0] coin_add;

    recipe_t sel_recipe;
    logic type_ok;
    logic first_found, next_found;
    logic [IDX_W-1:0] first_idx, next_idx;
    logic timer_start, timer_done;
    logic [DUR_W-1:0] timer_dur;

    function automatic logic [CREDIT_W-1:0] sat_credit(input logic [SUM_W-1:0] v);
        return (v > SUM_W'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT) : v[CREDIT_W-1:0];
    endfunction

    assign coin_100_rise = coin_100 & ~coin_100_q;
    assign confirm_rise  = confirm & ~confirm_q;
    assign cancel_rise   = cancel & ~cancel_q;

`ifdef COIN_500_EN
    logic coin_500_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) coin_500_q <= 1'b0;
        else       coin_500_q <= coin_500;
    end
    assign coin_500_rise = coin_500 & ~coin_500_q;
`else
    assign coin_500_rise = 1'b0;
`endif

    assign coin_add = SUM_W'(coin_100_rise) + (coin_500_rise ? SUM_W'(5) : '0);

    assign sel_recipe = recipe_lookup(coffee_type);
    assign type_ok    = 32'(coffee_type) < NUM_RECIPES;

    // Lowest non-zero step of the selected recipe, and the next non-zero step
    // after the current one, so zero-duration ingredients cost no cycle.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        for (int i = NUM_INGR - 1; i >= 0; i--) begin
            if (sel_recipe.dur[i] != '0) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = NUM_INGR - 1; i >= 0; i--) begin
            if (i > int'(step_idx) && dur_q[i] != '0) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end
    end

    step_timer #(
        .TICK_DIV (TICK_DIV),
        .DUR_W    (DUR_W)
    ) u_step_timer (
        .clock    (clock),
        .reset    (reset),
        .start    (timer_start),
        .duration (timer_dur),
        .done     (timer_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            credit       <= '0;
            change       <= '0;
            change_valid <= 1'b0;
            finished     <= 1'b0;
            err          <= 1'b0;
            dur_q        <= '0;
            step_idx     <= '0;
            no_steps     <= 1'b0;
            coin_100_q   <= 1'b0;
            confirm_q    <= 1'b0;
            cancel_q     <= 1'b0;
        end else begin
            state        <= state_next;
            credit       <= credit_next;
            change       <= change_next;
            change_valid <= change_valid_next;
            finished     <= finished_next;
            err          <= err_next;
            dur_q        <= dur_next;
            step_idx     <= idx_next;
            no_steps     <= no_steps_next;
            coin_100_q   <= coin_100;
            confirm_q    <= confirm;
            cancel_q     <= cancel;
        end
    end

    always_comb begin
        state_next        = state;
        credit_next       = credit;
        change_next       = change;
        change_valid_next = 1'b0;
        finished_next     = 1'b0;
        err_next          = 1'b0;
        dur_next          = dur_q;
        idx_next          = step_idx;
        no_steps_next     = no_steps;
        timer_start       = 1'b0;
        timer_dur         = '0;
        unique case (state)
            ST_IDLE: begin
                if (confirm_rise) begin
                    // Affordability uses the credit held before this cycle's coin.
                    if (type_ok && credit >= sel_recipe.price) begin
                        state_next    = ST_DISPENSE;
                        dur_next      = sel_recipe.dur;
                        credit_next   = sat_credit(SUM_W'(credit) - SUM_W'(sel_recipe.price) + coin_add);
                        idx_next      = first_idx;
                        no_steps_next = !first_found;
                        timer_start   = first_found;
                        timer_dur     = sel_recipe.dur[first_idx];
                    end else begin
                        err_next    = 1'b1;
                        credit_next = sat_credit(SUM_W'(credit) + coin_add);
                    end
                end else if (cancel_rise) begin
                    change_next       = sat_credit(SUM_W'(credit) + coin_add);
                    change_valid_next = 1'b1;
                    credit_next       = '0;
                end else begin
                    credit_next = sat_credit(SUM_W'(credit) + coin_add);
                end
            end
            ST_DISPENSE: begin
                if (no_steps || (timer_done && !next_found)) begin
                    state_next        = ST_DONE;
                    finished_next     = 1'b1;
                    change_next       = credit;
                    change_valid_next = 1'b1;
                    credit_next       = '0;
                end else if (timer_done) begin
                    idx_next    = next_idx;
                    timer_start = 1'b1;
                    timer_dur   = dur_q[next_idx];
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ingr_en = '0;
        for (int i = 0; i < NUM_INGR; i++) begin
            ingr_en[i] = (state == ST_DISPENSE) && !no_steps && (step_idx == IDX_W'(i));
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule
